vga_plot_sink: RTL and testbench
================================

Name: vga_plot_sink

Overview:
- Receiving end of the pixel-plot interface (X, Y, colour, plot strobe) that the box and line drawing FSMs drive.
- Stores plotted pixels in a 160x120x3 frame buffer.
- Continuously scans the buffer out as 640x480 VGA timing, with each stored pixel replicated 4x4.
- Sits between the drawing datapaths and the board VGA pins; uses one clock, the 25 MHz pixel clock.

Parameters:
- FB_W, 160, frame buffer width in pixels.
- FB_H, 120, frame buffer height in pixels.
- SCALE_LOG2, 2, log2 of pixel replication factor (active area = FB_W<<SCALE_LOG2 by FB_H<<SCALE_LOG2).
- H_FP, 16, horizontal front porch in clocks.
- H_SYNC, 96, horizontal sync width in clocks.
- H_BP, 48, horizontal back porch in clocks.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- BG_COLOUR, 3'b000, colour used by the clear sequence (see Optional Feature).

Ports:
- iClock  in  1  pixel clock; all logic on rising edge.
- iResetn  in  1  asynchronous active-low reset.
- iX  in  8  plot X coordinate, valid range 0..FB_W-1.
- iY  in  7  plot Y coordinate, valid range 0..FB_H-1.
- iColour  in  3  plot colour; bit2=R, bit1=G, bit0=B.
- iPlot  in  1  write strobe; one pixel written per cycle it is high.
- oReady  out  1  high when writes are accepted.
- oOob  out  1  sticky flag: an out-of-range plot was attempted.
- oHS  out  1  horizontal sync, active low.
- oVS  out  1  vertical sync, active low.
- oBlank_n  out  1  high during the active display area.
- oR  out  1  red.
- oG  out  1  green.
- oB  out  1  blue.
- oFrameStart  out  1  one-cycle pulse at pixel (0,0) of each frame.

Behaviour:
Reset (asynchronous, iResetn=0):
- hcount=0, vcount=0.
- All outputs 0, except oHS=1 and oVS=1 (inactive).
- oOob cleared.
- oReady=0 while in reset.
- Frame buffer contents are not touched by reset.

Timing counters:
- hcount runs 0..H_TOTAL-1 with H_TOTAL = 640+H_FP+H_SYNC+H_BP = 800, then wraps to 0.
- vcount increments when hcount wraps and runs 0..V_TOTAL-1 with V_TOTAL = 525, then wraps to 0.
- Active area: hcount<640 and vcount<480.
- HS asserted (low) for hcount in [640+H_FP, 640+H_FP+H_SYNC).
- VS asserted (low) for vcount in [480+V_FP, 480+V_FP+V_SYNC).

Read path:
- Read address = (vcount>>SCALE_LOG2)*FB_W + (hcount>>SCALE_LOG2), 15 bits.
- The buffer read is registered.
- oHS, oVS, oBlank_n and oFrameStart are delayed through one register stage so all VGA outputs align.
- Total latency from counter value to pins: 1 cycle.
- oR/oG/oB are forced to 0 whenever oBlank_n=0.

Write path:
- On a rising edge with iPlot=1, oReady=1, iX<FB_W and iY<FB_H: mem[iY*FB_W+iX] <= iColour.
- A plot with out-of-range coordinates is dropped and sets oOob=1. oOob clears only on reset.
- iPlot while oReady=0 is dropped silently; oOob is not set.
- Write and read never stall each other (dual-port).
- Write and read to the same address in the same cycle: the read returns the old data, and the new colour appears on the next frame.
- Back-to-back writes are accepted every cycle; no handshake beyond oReady.

oReady:
- Without FB_CLEAR_EN: oReady goes to 1 on the first clock edge after reset deassertion.
- With FB_CLEAR_EN: see Optional Feature.

Reset mid-frame:
- Counters return to 0 asynchronously.
- A new frame starts on the first clock after release, and oFrameStart pulses 1 cycle later.

Optional Feature:
Macro: VGA_PLOT_SINK_CLEAR_EN

With the macro defined:
- After reset release, an internal FSM runs CLEAR -> RUN.
- CLEAR writes BG_COLOUR to addresses 0..FB_W*FB_H-1, one address per cycle (19200 cycles).
- oReady=0 throughout CLEAR; external plots are dropped.
- oReady rises on the cycle after the last clear write.
- Scan-out runs during CLEAR.

Without the macro:
- No clear FSM; oReady=1 from the first post-reset clock edge.
- Buffer contents after power-up are undefined.

Test Plan:
- Hold iResetn=0 for 3 cycles, then release -> oHS=1, oVS=1, oBlank_n=0 during reset; oFrameStart pulses exactly 1 cycle after the first post-reset edge; the next pulse follows 420000 cycles later (800x525).
- Free-run one frame -> oHS low for 96 cycles starting 656 cycles after each line start; oVS low for lines 490..491; oBlank_n high for exactly 640x480 cycles per frame.
- Plot iX=5, iY=3, iColour=3'b101 -> on the next frame oR=1, oG=0, oB=1 for hcount 20..23 on vcount 12..15 (pins lag by 1 cycle); neighbouring pixels are unchanged.
- Plot iX=160, iY=0, and separately iX=0, iY=120 -> memory unchanged; oOob=1 and remains 1 until reset.
- Write iX=0, iY=0, colour 3'b010 on the same cycle the scan reads address 0 -> the current frame shows the old colour; the next frame shows green.
- With VGA_PLOT_SINK_CLEAR_EN and BG_COLOUR=3'b001: release reset -> oReady=0 for 19200 cycles; a plot issued during that window is dropped; after oReady rises the whole active area reads blue.

Source files
------------

// File: rtl/vga_plot_sink_if.sv
// Pixel-plot bus between the drawing datapaths and the frame-buffer sink.
// The drawing side is the master; the sink returns oReady.
interface vga_plot_sink_if;
  logic [7:0] iX;
  logic [6:0] iY;
  logic [2:0] iColour;
  logic       iPlot;
  logic       oReady;

  modport master (
    output iX,
    output iY,
    output iColour,
    output iPlot,
    input  oReady
  );

  modport slave (
    input  iX,
    input  iY,
    input  iColour,
    input  iPlot,
    output oReady
  );
endinterface

// File: rtl/vga_plot_sink.sv
// Frame-buffer plot sink with 4x4-replicated VGA scan-out; VGA_PLOT_SINK_CLEAR_EN adds a post-reset buffer clear.
// Latency: plot lands one edge after iPlot; VGA pins trail the scan counters by one cycle.
// Backpressure: none beyond oReady; plots with oReady=0 are dropped, scan-out never stalls.
module vga_plot_sink #(
  parameter int         FB_W       = 160,
  parameter int         FB_H       = 120,
  parameter int         SCALE_LOG2 = 2,
  parameter int         H_FP       = 16,
  parameter int         H_SYNC     = 96,
  parameter int         H_BP       = 48,
  parameter int         V_FP       = 10,
  parameter int         V_SYNC     = 2,
  parameter int         V_BP       = 33,
  parameter logic [2:0] BG_COLOUR  = 3'b000
) (
  input  logic             iClock,
  input  logic             iResetn,
  vga_plot_sink_if.slave   plot,
  output logic             oOob,
  output logic             oHS,
  output logic             oVS,
  output logic             oBlank_n,
  output logic             oR,
  output logic             oG,
  output logic             oB,
  output logic             oFrameStart
);

  localparam int H_ACT    = FB_W << SCALE_LOG2;
  localparam int V_ACT    = FB_H << SCALE_LOG2;
  localparam int H_TOTAL  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACT + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACT + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int N_PIX    = FB_W * FB_H;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int AW       = 15;
  localparam int MW       = $clog2(N_PIX);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          active;
  logic          hs_n;
  logic          vs_n;
  logic          frame_origin;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_dat;

  logic          hs_q;
  logic          vs_q;
  logic          blank_q;
  logic          fs_q;
  logic          oob_q;
  logic          ready_q;

  logic          in_range;
  logic          plot_acc;
  logic          plot_oob;
  logic [AW-1:0] wr_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [2:0]    mem_wdat;

  logic [2:0]    mem [N_PIX];

  // Scan counters
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == HW'(H_TOTAL - 1)) begin
      hcount <= '0;
      if (vcount == VW'(V_TOTAL - 1)) vcount <= '0;
      else                            vcount <= vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  always_comb begin
    active       = (hcount < HW'(H_ACT)) && (vcount < VW'(V_ACT));
    hs_n         = !((hcount >= HW'(HS_START)) && (hcount < HW'(HS_END)));
    vs_n         = !((vcount >= VW'(VS_START)) && (vcount < VW'(VS_END)));
    frame_origin = (hcount == '0) && (vcount == '0);
    // Outside the active area the address is parked at 0 to stay inside the buffer.
    rd_addr      = active ? AW'(int'(vcount >> SCALE_LOG2) * FB_W + int'(hcount >> SCALE_LOG2))
                          : '0;
  end

  always_comb begin
    in_range = (int'(plot.iX) < FB_W) && (int'(plot.iY) < FB_H);
    plot_acc = plot.iPlot && ready_q && in_range;
    plot_oob = plot.iPlot && ready_q && !in_range;
    wr_addr  = AW'(int'(plot.iY) * FB_W + int'(plot.iX));
  end

`ifdef VGA_PLOT_SINK_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_addr;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == AW'(N_PIX - 1)) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Clear owns the write port until it finishes; ready_q keeps external plots out.
  always_comb begin
    mem_we    = (state == ST_CLEAR) || plot_acc;
    mem_waddr = (state == ST_CLEAR) ? clr_addr : wr_addr;
    mem_wdat  = (state == ST_CLEAR) ? BG_COLOUR : plot.iColour;
  end
`else
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) ready_q <= 1'b0;
    else          ready_q <= 1'b1;
  end

  always_comb begin
    mem_we    = plot_acc;
    mem_waddr = wr_addr;
    mem_wdat  = plot.iColour;
  end
`endif

  assign plot.oReady = ready_q;

  // Buffer is never reset; a same-address write and read returns the old colour.
  always_ff @(posedge iClock) begin
    if (mem_we) mem[mem_waddr[MW-1:0]] <= mem_wdat;
    rd_dat <= mem[rd_addr[MW-1:0]];
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      hs_q    <= hs_n;
      vs_q    <= vs_n;
      blank_q <= active;
      fs_q    <= frame_origin;
      if (plot_oob) oob_q <= 1'b1;
    end
  end

  assign oHS         = hs_q;
  assign oVS         = vs_q;
  assign oBlank_n    = blank_q;
  assign oFrameStart = fs_q;
  assign oOob        = oob_q;
  assign oR          = rd_dat[2] & blank_q;
  assign oG          = rd_dat[1] & blank_q;
  assign oB          = rd_dat[0] & blank_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed bench for vga_plot_sink on a shrunken 8x6 buffer (32x24 active, 40x29 total) so frames stay short.
// Bench variable pos is the scan position shown on the pins at each sample, 1 ns after the rising edge.
module tb_vga_plot_sink;
  localparam int FBW   = 8;
  localparam int HT    = 40;
  localparam int FRAME = 1160;
  localparam int NPIX  = 48;

  logic clk = 1'b0;
  logic rst_n;
  logic oob, hs, vs, blank_n, r, g, b, fs;

  int checks = 0;
  int errors = 0;
  int pos    = 0;

  logic [2:0] img [NPIX];
  logic [2:0] cap [24][32];

  vga_plot_sink_if pif ();

  vga_plot_sink #(
    .FB_W(8), .FB_H(6), .SCALE_LOG2(2),
    .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_FP(1), .V_SYNC(2), .V_BP(2),
    .BG_COLOUR(3'b001)
  ) dut (
    .iClock(clk), .iResetn(rst_n), .plot(pif),
    .oOob(oob), .oHS(hs), .oVS(vs), .oBlank_n(blank_n),
    .oR(r), .oG(g), .oB(b), .oFrameStart(fs)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
    pos = (pos + 1) % FRAME;
  endtask

  task automatic step_to(input int target);
    for (int i = 0; i < FRAME && pos != target; i++) step();
  endtask

  task automatic plot_px(input int x, input int y, input logic [2:0] c);
    pif.iX      = 8'(x);
    pif.iY      = 7'(y);
    pif.iColour = c;
    pif.iPlot   = 1'b1;
    step();
    pif.iPlot   = 1'b0;
  endtask

  task automatic capture();
    step_to(0);
    for (int p = 0; p < FRAME; p++) begin
      if ((p % HT) < 32 && (p / HT) < 24) cap[p / HT][p % HT] = {r, g, b};
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pif.iPlot = 1'b0; pif.iX = '0; pif.iY = '0; pif.iColour = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hs, vs, blank_n, fs} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_sync: hs/vs/blank/fs=%b required 1100", {hs, vs, blank_n, fs});
    end
    checks++;
    if ({pif.oReady, oob, r, g, b} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_misc: ready/oob/rgb=%b required 00000", {pif.oReady, oob, r, g, b});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pos = 0;
    checks++;
    if (fs !== 1'b1 || blank_n !== 1'b1) begin
      errors++;
      $display("FAIL first_frame_start: fs=%b blank_n=%b required 1 1", fs, blank_n);
    end
    checks++;
`ifdef VGA_PLOT_SINK_CLEAR_EN
    if (pif.oReady !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release: got %b required 0", pif.oReady);
    end
`else
    if (pif.oReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b required 1", pif.oReady);
    end
`endif
  endtask

`ifdef VGA_PLOT_SINK_CLEAR_EN
  task automatic test_clear();
    int n = 0;
    int bad = 0;
    plot_px(2, 2, 3'b100);
    while (pif.oReady !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (pos !== NPIX - 1) begin
      errors++;
      $display("FAIL clear_ready_rise: rose at pos %0d required %0d", pos, NPIX - 1);
    end
    checks++;
    if (oob !== 1'b0) begin
      errors++;
      $display("FAIL clear_drop_oob: oob=%b required 0", oob);
    end
    for (int i = 0; i < NPIX; i++) img[i] = 3'b001;
    capture();
    for (int v = 0; v < 24; v++)
      for (int h = 0; h < 32; h++)
        if (cap[v][h] !== 3'b001) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL clear_all_blue: %0d pixels wrong, required 0", bad);
    end
  endtask
`endif

  task automatic test_timing();
    int bad_hs = 0, bad_vs = 0, bad_blank = 0, bad_fs = 0;
    int blank_cnt = 0, hs_cnt = 0, vs_cnt = 0, rgb_blank = 0;
    step_to(0);
    for (int p = 0; p < FRAME; p++) begin
      int h, v;
      h = p % HT;
      v = p / HT;
      if (hs !== ((h >= 34 && h < 38) ? 1'b0 : 1'b1)) bad_hs++;
      if (vs !== ((v >= 25 && v < 27) ? 1'b0 : 1'b1)) bad_vs++;
      if (blank_n !== ((h < 32 && v < 24) ? 1'b1 : 1'b0)) bad_blank++;
      if (fs !== ((p == 0) ? 1'b1 : 1'b0)) bad_fs++;
      if (blank_n === 1'b1) blank_cnt++;
      if (hs === 1'b0) hs_cnt++;
      if (vs === 1'b0) vs_cnt++;
      if (blank_n === 1'b0 && {r, g, b} !== 3'b000) rgb_blank++;
      step();
    end
    checks++;
    if (bad_hs !== 0) begin errors++; $display("FAIL hs_position: %0d wrong samples, required 0", bad_hs); end
    checks++;
    if (bad_vs !== 0) begin errors++; $display("FAIL vs_position: %0d wrong samples, required 0", bad_vs); end
    checks++;
    if (bad_blank !== 0) begin errors++; $display("FAIL blank_position: %0d wrong samples, required 0", bad_blank); end
    checks++;
    if (bad_fs !== 0) begin errors++; $display("FAIL frame_start_once: %0d wrong samples, required 0", bad_fs); end
    checks++;
    if (blank_cnt !== 768) begin errors++; $display("FAIL blank_count: got %0d required 768", blank_cnt); end
    checks++;
    if (hs_cnt !== 116) begin errors++; $display("FAIL hs_count: got %0d required 116", hs_cnt); end
    checks++;
    if (vs_cnt !== 80) begin errors++; $display("FAIL vs_count: got %0d required 80", vs_cnt); end
    checks++;
    if (rgb_blank !== 0) begin errors++; $display("FAIL rgb_in_blank: %0d samples lit, required 0", rgb_blank); end
    checks++;
    if (fs !== 1'b1) begin errors++; $display("FAIL frame_period: fs=%b after %0d cycles, required 1", fs, FRAME); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < FBW; x++) begin
        plot_px(x, y, 3'b110);
        img[y * FBW + x] = 3'b110;
      end
    capture();
    for (int v = 0; v < 24; v++)
      for (int h = 0; h < 32; h++)
        if (cap[v][h] !== img[(v / 4) * FBW + h / 4]) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL fill_image: %0d pixels wrong, required 0", bad); end
  endtask

  task automatic test_plot();
    int bad = 0, region = 0;
    plot_px(5, 3, 3'b101);
    img[3 * FBW + 5] = 3'b101;
    capture();
    for (int v = 0; v < 24; v++)
      for (int h = 0; h < 32; h++) begin
        if (cap[v][h] !== img[(v / 4) * FBW + h / 4]) bad++;
        if (v >= 12 && v <= 15 && h >= 20 && h <= 23 && cap[v][h] === 3'b101) region++;
      end
    checks++;
    if (region !== 16) begin errors++; $display("FAIL plot_block: %0d magenta pixels at (20..23,12..15), required 16", region); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL plot_image: %0d pixels wrong, required 0", bad); end
  endtask

  task automatic test_oob();
    int bad = 0;
    checks++;
    if (oob !== 1'b0) begin errors++; $display("FAIL oob_initial: got %b required 0", oob); end
    plot_px(8, 0, 3'b001);
    checks++;
    if (oob !== 1'b1) begin errors++; $display("FAIL oob_x: got %b required 1", oob); end
    plot_px(0, 6, 3'b001);
    checks++;
    if (oob !== 1'b1) begin errors++; $display("FAIL oob_y: got %b required 1", oob); end
    capture();
    for (int v = 0; v < 24; v++)
      for (int h = 0; h < 32; h++)
        if (cap[v][h] !== img[(v / 4) * FBW + h / 4]) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL oob_no_write: %0d pixels wrong, required 0", bad); end
    checks++;
    if (oob !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b required 1", oob); end
  endtask

  task automatic test_collision();
    // Scan position 123 is (h=3,v=3): the last read of address 0 in the frame.
    step_to(122);
    plot_px(0, 0, 3'b010);
    checks++;
    if ({r, g, b} !== 3'b110) begin errors++; $display("FAIL collision_old: rgb=%b required 110", {r, g, b}); end
    img[0] = 3'b010;
    step_to(0);
    checks++;
    if ({r, g, b} !== 3'b010) begin errors++; $display("FAIL collision_next_origin: rgb=%b required 010", {r, g, b}); end
    step_to(123);
    checks++;
    if ({r, g, b} !== 3'b010) begin errors++; $display("FAIL collision_next_pixel: rgb=%b required 010", {r, g, b}); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    step_to(500);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hs, vs, blank_n, fs, pif.oReady, oob} !== 6'b110000) begin
      errors++;
      $display("FAIL mid_reset_outputs: hs/vs/blank/fs/ready/oob=%b required 110000",
               {hs, vs, blank_n, fs, pif.oReady, oob});
    end
    repeat (2) @(posedge clk);
    #1;
    pif.iX = 8'd1; pif.iY = 7'd1; pif.iColour = 3'b100; pif.iPlot = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pos = 0;
    pif.iPlot = 1'b0;
    checks++;
    if (fs !== 1'b1) begin errors++; $display("FAIL mid_reset_frame_start: fs=%b required 1", fs); end
`ifdef VGA_PLOT_SINK_CLEAR_EN
    for (int i = 0; i < 200 && pif.oReady !== 1'b1; i++) step();
    for (int i = 0; i < NPIX; i++) img[i] = 3'b001;
`endif
    capture();
    for (int v = 0; v < 24; v++)
      for (int h = 0; h < 32; h++)
        if (cap[v][h] !== img[(v / 4) * FBW + h / 4]) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL mid_reset_image: %0d pixels wrong, required 0", bad); end
    checks++;
    if (oob !== 1'b0) begin errors++; $display("FAIL not_ready_drop_oob: got %b required 0", oob); end
  endtask

  initial begin
    test_reset();
`ifdef VGA_PLOT_SINK_CLEAR_EN
    test_clear();
`endif
    test_timing();
    test_back_to_back();
    test_plot();
    test_oob();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
